// File: rtl/lsu_dtag_err_ctl_pkg.sv
// ---------------------------------------------------------------------------
// lsu_dtag_err_ctl_pkg
//   Shared definitions for the L1D tag/valid error and diagnostic sequencer:
//   default geometry, error-queue entry width and the FSM state encoding.
//   Imported by lsu_dtag_errq and lsu_dtag_err_ctl.
// ---------------------------------------------------------------------------
package lsu_dtag_err_ctl_pkg;

    localparam int DTAG_INDEX_W      = 7;   // 128 sets
    localparam int DTAG_WAYS         = 4;   // associativity, one-hot vectors
    localparam int DTAG_ERRQ_DEPTH   = 2;   // error queue entries
    // One queue entry is {set index, way mask}.
    localparam int DTAG_ERRQ_ENTRY_W = DTAG_INDEX_W + DTAG_WAYS;

    // IDLE    : waiting for a granted slot
    // INV     : one-cycle valid-array invalidate of the queue head
    // DRD_E   : diagnostic tag read sits in M, way select driven
    // DRD_M   : diagnostic data lands in the G-stage flop, done pulses
    // DRD_G   : reserved encoding, treated as IDLE
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INV   = 3'd1,
        ST_DRD_E = 3'd2,
        ST_DRD_M = 3'd3,
        ST_DRD_G = 3'd4
    } dtag_state_e;

endpackage

// File: rtl/lsu_dtag_errq.sv
// ---------------------------------------------------------------------------
// lsu_dtag_errq
//   Small synchronous FIFO of tag-parity error records {index, way mask}.
//   A push whose index matches the tail entry ORs its mask into that entry
//   instead of allocating a new one. A push while full is dropped unless a
//   pop in the same cycle frees an entry.
//
// Ports
//   clk, rst_l       clock, asynchronous active-low reset
//   push             capture request
//   push_index/mask  record to capture
//   pop              retire the head entry (ignored when empty)
//   head_index/mask  head entry contents
//   empty            no entries held
//   near_full        registered: count >= DEPTH-1
//   drop             this cycle's push was lost (queue full, no merge/pop)
// ---------------------------------------------------------------------------
module lsu_dtag_errq
    import lsu_dtag_err_ctl_pkg::*;
#(
    parameter int INDEX_W = DTAG_INDEX_W,
    parameter int WAYS    = DTAG_WAYS,
    parameter int DEPTH   = DTAG_ERRQ_DEPTH,
    parameter int ENTRY_W = DTAG_ERRQ_ENTRY_W
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               push,
    input  logic [INDEX_W-1:0] push_index,
    input  logic [WAYS-1:0]    push_mask,
    input  logic               pop,
    output logic [INDEX_W-1:0] head_index,
    output logic [WAYS-1:0]    head_mask,
    output logic               empty,
    output logic               near_full,
    output logic               drop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   tail_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic               full;
    logic               do_pop;
    logic               merge;
    logic               do_write;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    // DEPTH is a power of two, so the pointer wraps naturally.
    assign tail_ptr = wr_ptr - PTR_W'(1);
    assign do_pop   = pop & ~empty;

    // Never merge into an entry that is being retired this cycle: its mask
    // has already gone out on the invalidate port.
    assign merge    = push & ~empty
                    & (mem[tail_ptr][ENTRY_W-1:WAYS] == push_index)
                    & ~(do_pop & (count == CNT_W'(1)));
    assign do_write = push & ~merge & (~full | do_pop);
    assign drop     = push & ~merge & ~do_write;

    assign count_nxt = count + CNT_W'(do_write) - CNT_W'(do_pop);

    assign head_index = mem[rd_ptr][ENTRY_W-1:WAYS];
    assign head_mask  = mem[rd_ptr][WAYS-1:0];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            near_full <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_nxt;
            near_full <= (count_nxt >= CNT_W'(DEPTH - 1));
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read while
    // count says it holds valid data, so resetting it would just cost flops.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= {push_index, push_mask};
        end else if (merge) begin
            mem[tail_ptr][WAYS-1:0] <= mem[tail_ptr][WAYS-1:0] | push_mask;
        end
    end

endmodule

// File: rtl/lsu_dtag_err_ctl.sv
// ---------------------------------------------------------------------------
// lsu_dtag_err_ctl
//   Sequencer for the L1D tag/valid datapath. Queues per-way tag parity
//   errors seen in G and invalidates the erroring ways through the valid
//   array write port in LSU-granted slots. Also runs diagnostic (ASI) tag
//   reads: tag read in E, one-hot way select in M, done when the G data is
//   in the misc read-data flop.
//
// Optional feature: define LSU_DTAG_ERR_CNT_EN for a saturating 8-bit count
//   of all error captures (accepted, merged or dropped). Otherwise
//   dtag_err_cnt is tied to zero.
//
// Ports
//   rclk, rst_l                  clock, asynchronous active-low reset
//   tag_chk_vld_g, tag_index_g   tag lookup in G and its set index
//   lsu_rd_dtag_parity_g         per-way parity error
//   dva_vld_g                    per-way valid bits of that set
//   lsu_slot_free_e              tag/valid port idle in E this cycle
//   asi_tagrd_req/index/way      diagnostic read request (level)
//   dtag_rd_en_e/index_e         controller-owned tag read in E
//   lsu_dtag_rsel_m              one-hot way select in M
//   dva_inv_en/index/wmask       valid-array invalidate
//   asi_tagrd_done               diag data valid in misc rdata next cycle
//   lsu_dtag_err_stall           hold new lookups (queue nearly full)
//   dtag_err_ovfl                sticky: an error record was dropped
//   dtag_err_cnt                 saturating error count
// ---------------------------------------------------------------------------
module lsu_dtag_err_ctl
    import lsu_dtag_err_ctl_pkg::*;
#(
    parameter int INDEX_W    = DTAG_INDEX_W,
    parameter int WAYS       = DTAG_WAYS,
    parameter int ERRQ_DEPTH = DTAG_ERRQ_DEPTH
) (
    input  logic               rclk,
    input  logic               rst_l,
    input  logic               tag_chk_vld_g,
    input  logic [INDEX_W-1:0] tag_index_g,
    input  logic [WAYS-1:0]    lsu_rd_dtag_parity_g,
    input  logic [WAYS-1:0]    dva_vld_g,
    input  logic               lsu_slot_free_e,
    input  logic               asi_tagrd_req,
    input  logic [INDEX_W-1:0] asi_tagrd_index,
    input  logic [1:0]         asi_tagrd_way,
    output logic               dtag_rd_en_e,
    output logic [INDEX_W-1:0] dtag_rd_index_e,
    output logic [WAYS-1:0]    lsu_dtag_rsel_m,
    output logic               dva_inv_en,
    output logic [INDEX_W-1:0] dva_inv_index,
    output logic [WAYS-1:0]    dva_inv_wmask,
    output logic               asi_tagrd_done,
    output logic               lsu_dtag_err_stall,
    output logic               dtag_err_ovfl,
    output logic [7:0]         dtag_err_cnt
);

    dtag_state_e        state;
    dtag_state_e        state_nxt;
    logic [WAYS-1:0]    err_mask;
    logic               capture;
    logic               q_pop;
    logic               q_empty;
    logic               q_near_full;
    logic               q_drop;
    logic [INDEX_W-1:0] q_head_index;
    logic [WAYS-1:0]    q_head_mask;
    logic               diag_start;
    logic [1:0]         diag_way;

    // Only ways that are actually valid need invalidating.
    assign err_mask = lsu_rd_dtag_parity_g & dva_vld_g;
    assign capture  = tag_chk_vld_g & (|err_mask);

    lsu_dtag_errq #(
        .INDEX_W (INDEX_W),
        .WAYS    (WAYS),
        .DEPTH   (ERRQ_DEPTH),
        .ENTRY_W (INDEX_W + WAYS)
    ) u_errq (
        .clk        (rclk),
        .rst_l      (rst_l),
        .push       (capture),
        .push_index (tag_index_g),
        .push_mask  (err_mask),
        .pop        (q_pop),
        .head_index (q_head_index),
        .head_mask  (q_head_mask),
        .empty      (q_empty),
        .near_full  (q_near_full),
        .drop       (q_drop)
    );

    assign lsu_dtag_err_stall = q_near_full;

    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            state         <= ST_IDLE;
            diag_way      <= 2'd0;
            dtag_err_ovfl <= 1'b0;
        end else begin
            state <= state_nxt;
            // Way is latched at grant so the M-stage select cannot shift
            // if the requester changes it mid-operation.
            if (diag_start) diag_way <= asi_tagrd_way;
            if (q_drop)     dtag_err_ovfl <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt       = state;
        diag_start      = 1'b0;
        q_pop           = 1'b0;
        dtag_rd_en_e    = 1'b0;
        dtag_rd_index_e = '0;
        lsu_dtag_rsel_m = '0;
        dva_inv_en      = 1'b0;
        dva_inv_index   = '0;
        dva_inv_wmask   = '0;
        asi_tagrd_done  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!q_empty && lsu_slot_free_e) begin
                    state_nxt = ST_INV;
                end else if (asi_tagrd_req && lsu_slot_free_e && rst_l) begin
                    // The read launches combinationally in the granted slot;
                    // rst_l gating keeps it quiet while reset is held.
                    diag_start      = 1'b1;
                    dtag_rd_en_e    = 1'b1;
                    dtag_rd_index_e = asi_tagrd_index;
                    state_nxt       = ST_DRD_E;
                end
            end
            ST_INV: begin
                dva_inv_en    = 1'b1;
                dva_inv_index = q_head_index;
                dva_inv_wmask = q_head_mask;
                q_pop         = 1'b1;
                state_nxt     = ST_IDLE;
            end
            ST_DRD_E: begin
                // Out-of-range way indices leave the select all-zero.
                for (int i = 0; i < WAYS; i++) begin
                    lsu_dtag_rsel_m[i] = (int'(diag_way) == i);
                end
                state_nxt = ST_DRD_M;
            end
            ST_DRD_M: begin
                asi_tagrd_done = 1'b1;
                state_nxt      = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef LSU_DTAG_ERR_CNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            err_cnt <= 8'h00;
        end else if (capture && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign dtag_err_cnt = err_cnt;
`else
    assign dtag_err_cnt = 8'h00;
`endif

endmodule

// File: doc/lsu_dtag_err_ctl.md
Name: lsu_dtag_err_ctl

Overview:
- Sequencer for the L1D tag/valid datapath. Captures per-way tag parity errors reported in the G stage and queues them.
- Invalidates the erroring ways through the valid-array write port, using only pipeline slots the LSU grants.
- Also sequences diagnostic (ASI) tag reads: it drives the tag read index and the one-hot M-stage way select, then signals completion once the G-stage data is in the misc read-data flop.

Parameters:
- INDEX_W, 7, L1D set-index width (128 sets)
- WAYS, 4, L1D associativity; one-hot vectors are WAYS bits
- ERRQ_DEPTH, 2, error queue entries (power of two, >=2)

Ports:
- rclk  in  1  clock
- rst_l  in  1  asynchronous active-low reset
- tag_chk_vld_g  in  1  a tag lookup occupied G this cycle
- tag_index_g  in  INDEX_W  set index of that lookup
- lsu_rd_dtag_parity_g  in  WAYS  per-way parity error from tag datapath
- dva_vld_g  in  WAYS  valid bits of that set, flopped to G
- lsu_slot_free_e  in  1  pipeline leaves tag/valid port idle in E this cycle
- asi_tagrd_req  in  1  diagnostic tag read request (level, held until done)
- asi_tagrd_index  in  INDEX_W  diagnostic index
- asi_tagrd_way  in  2  diagnostic way
- dtag_rd_en_e  out  1  controller-owned tag read in E
- dtag_rd_index_e  out  INDEX_W  index for that read
- lsu_dtag_rsel_m  out  WAYS  one-hot way select in M (0 when not diag)
- dva_inv_en  out  1  valid-array invalidate strobe
- dva_inv_index  out  INDEX_W  set to invalidate
- dva_inv_wmask  out  WAYS  ways to clear
- asi_tagrd_done  out  1  one-cycle pulse: diag data valid in lsu_misc_rdata_w2 next cycle
- lsu_dtag_err_stall  out  1  request pipeline to hold new lookups
- dtag_err_ovfl  out  1  sticky: an error was dropped
- dtag_err_cnt  out  8  saturating error count (optional feature)

Behaviour:
- Reset (async, rst_l low): all outputs 0, queue empty, FSM IDLE, ovfl and cnt cleared. Any in-flight scrub or diag read is abandoned. A request still high after reset release restarts from IDLE.
- Capture: err_mask = lsu_rd_dtag_parity_g & dva_vld_g. If tag_chk_vld_g and err_mask != 0, push {tag_index_g, err_mask}.
- Merge: if the push index equals the tail entry's index, OR the masks instead of pushing.
- Full: a push while full (no merge) is dropped and sets dtag_err_ovfl, which stays set until reset.
- Simultaneous push and pop while full: the pop frees the entry, so the push is accepted.
- lsu_dtag_err_stall = queue count >= ERRQ_DEPTH-1, registered.
- FSM states: IDLE, INV, DRD_E, DRD_M, DRD_G.
- IDLE:
  - If queue non-empty and lsu_slot_free_e: go to INV. Scrub has priority over diag.
  - Else if asi_tagrd_req and lsu_slot_free_e: dtag_rd_en_e=1, index=asi_tagrd_index, go to DRD_E.
  - Without a free slot, stay in IDLE.
- INV (1 cycle): dva_inv_en=1 with the head entry's index/mask; pop; go to IDLE.
- DRD_E -> DRD_M: lsu_dtag_rsel_m = 1<<asi_tagrd_way for exactly this cycle.
- DRD_M -> DRD_G: assert asi_tagrd_done; go to IDLE.
- Diag latency: slot grant to done = 2 cycles. Diag ops are non-interruptible; errors arriving meanwhile queue normally.
- A new diag request is not accepted in the cycle done pulses; the requester must drop req on done.
- A way index >= WAYS selects nothing (rsel=0), but done still pulses.

Optional Feature:
- Macro LSU_DTAG_ERR_CNT_EN.
- Defined: dtag_err_cnt increments by 1 on every accepted or merged capture, and also on dropped captures. It saturates at 8'hFF and clears on reset.
- Undefined: dtag_err_cnt tied to 8'h00 and no counter flops exist.

Decomposition:
- Shared package/include: FSM state encodings, INDEX_W/WAYS defaults, queue-entry width constant (INDEX_W+WAYS).
- One natural sub-module: lsu_dtag_errq, a small synchronous FIFO with tail-merge, count, full/empty flags, async active-low reset.

Test Plan:
- Error way1 index 0x15, dva_vld=4'hF, slot free -> push; INV two cycles later with dva_inv_index=0x15, wmask=4'b0010; queue empty after.
- Parity error on way2 with dva_vld=4'b1011 -> no push, no invalidate; with LSU_DTAG_ERR_CNT_EN defined, cnt unchanged.
- Three distinct errors back-to-back, slot never free, depth 2 -> stall high after first, third dropped, ovfl=1, cnt=3. Two INV cycles once the slot frees.
- Diag read index 0x40, way 3, slot free at cycle t -> rd_en_e at t, rsel_m=4'b1000 at t+1, done at t+2, single pulse.
- Queued error and diag request pending with slot free -> INV first, diag read starts on the next free slot.
- rst_l asserted during DRD_M -> rsel and done go to 0 immediately, queue cleared; after release with req held, full 2-cycle diag sequence restarts.
